// File: rtl/serial_compare_ctrl.sv
// Bit-serial MSB-first magnitude comparator.
// One registered {p,q} cell; Zout = (A <= B).
module serial_compare_ctrl #(
  parameter int N          = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         Zout,
  output logic [1:0]   pq
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] PQ_EQ = 2'b01;
  localparam logic [1:0] PQ_GT = 2'b10;
  localparam logic [1:0] PQ_LT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic          r_z;
  logic [1:0]    r_pq;

  logic [1:0] w_pq_eff;
  logic [1:0] w_pq_nxt;
  logic       w_ai;
  logic       w_bi;
  logic       w_last;
  logic       w_exit;

  // Cell update from the current MSB pair; 00 behaves as "equal so far".
  always_comb begin
    w_ai     = r_a[N-1];
    w_bi     = r_b[N-1];
    w_pq_eff = (r_pq == 2'b00) ? PQ_EQ : r_pq;
    w_pq_nxt = w_pq_eff;
    if (w_pq_eff == PQ_EQ) begin
      if (w_ai == w_bi)
        w_pq_nxt = PQ_EQ;
      else if (w_ai)
        w_pq_nxt = PQ_GT;
      else
        w_pq_nxt = PQ_LT;
    end
    w_last = (r_cnt == '0);
    w_exit = w_last ||
             ((EARLY_EXIT != 0) && (w_pq_nxt != PQ_EQ));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_exit)
          w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand shift registers, bit counter, cell state and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_z   <= 1'b0;
      r_pq  <= PQ_EQ;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= A;
            r_b   <= B;
            r_pq  <= PQ_EQ;
            r_cnt <= CW'(N - 1);
          end
        end
        S_RUN: begin
          r_a   <= r_a << 1;
          r_b   <= r_b << 1;
          r_pq  <= w_pq_nxt;
          r_cnt <= (N == 1) ? '0 : r_cnt - CW'(1);
          if (w_exit)
            r_z <= (w_pq_nxt != PQ_GT);
        end
        default: ;
      endcase
    end
  end

  assign Zout = r_z;
  assign pq   = r_pq;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl.
// Instances: N=8 fixed, N=8 early-exit, N=1.
module tb_serial_compare_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st   [3];
  logic [7:0] Av   [3];
  logic [7:0] Bv   [3];
  logic       bz   [3];
  logic       dn   [3];
  logic       zo   [3];
  logic [1:0] pqo  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_compare_ctrl #(.N(8), .EARLY_EXIT(0)) u_fix (
    .clk(clk), .rst(rst), .start(st[0]),
    .A(Av[0]), .B(Bv[0]),
    .busy(bz[0]), .done(dn[0]), .Zout(zo[0]), .pq(pqo[0])
  );

  serial_compare_ctrl #(.N(8), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst(rst), .start(st[1]),
    .A(Av[1]), .B(Bv[1]),
    .busy(bz[1]), .done(dn[1]), .Zout(zo[1]), .pq(pqo[1])
  );

  serial_compare_ctrl #(.N(1), .EARLY_EXIT(0)) u_n1 (
    .clk(clk), .rst(rst), .start(st[2]),
    .A(Av[2][0:0]), .B(Bv[2][0:0]),
    .busy(bz[2]), .done(dn[2]), .Zout(zo[2]), .pq(pqo[2])
  );

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done; lat counts edges after the start edge.
  task automatic wait_done(input int d,
                           output int lat,
                           output int bcnt,
                           output logic [1:0] pq1);
    lat  = 0;
    bcnt = 0;
    pq1  = 2'bxx;
    while (!dn[d] && lat < 20) begin
      if (bz[d]) bcnt++;
      tick();
      lat++;
      if (lat == 1) pq1 = pqo[d];
    end
  endtask

  task automatic run(input int d,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input int exp_lat,
                     input int exp_z,
                     input int exp_pq,
                     input int exp_pq1,
                     input string tag);
    int         lat;
    int         bcnt;
    logic [1:0] pq1;
    tick();
    Av[d] = a;
    Bv[d] = b;
    st[d] = 1'b1;
    tick();
    st[d] = 1'b0;
    Av[d] = ~a;
    Bv[d] = ~b;
    chk({tag, "_busy0"}, bz[d], 1);
    wait_done(d, lat, bcnt, pq1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busycnt"}, bcnt, exp_lat);
    chk({tag, "_busy_at_done"}, bz[d], 0);
    chk({tag, "_z"}, zo[d], exp_z);
    chk({tag, "_pq"}, pqo[d], exp_pq);
    if (exp_pq1 >= 0)
      chk({tag, "_pq1"}, pq1, exp_pq1);
    tick();
    chk({tag, "_done_clr"}, dn[d], 0);
    chk({tag, "_pq_hold"}, pqo[d], exp_pq);
    chk({tag, "_z_hold"}, zo[d], exp_z);
  endtask

  initial begin
    int         lat;
    int         bcnt;
    int         seen;
    logic [1:0] pq1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      Av[i] = '0;
      Bv[i] = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_busy%0d", i), bz[i], 0);
      chk($sformatf("rst_done%0d", i), dn[i], 0);
      chk($sformatf("rst_z%0d", i), zo[i], 0);
      chk($sformatf("rst_pq%0d", i), pqo[i], 1);
    end

    // Fixed latency: equal, A>B at MSB, A<B at LSB.
    run(0, 8'h5A, 8'h5A, 8, 1, 2'b01, 2'b01, "eq");
    run(0, 8'h80, 8'h7F, 8, 0, 2'b10, 2'b10, "gt_msb");
    run(0, 8'h3C, 8'h3D, 8, 1, 2'b11, 2'b01, "lt_lsb");
    run(0, 8'hC3, 8'hC1, 8, 0, 2'b10, 2'b01, "gt_mid");

    // Early exit stops at the first differing bit.
    run(1, 8'h10, 8'h90, 1, 1, 2'b11, 2'b11, "ee_lt1");
    run(1, 8'h3C, 8'h3D, 8, 1, 2'b11, 2'b01, "ee_lt8");
    run(1, 8'hA5, 8'hA5, 8, 1, 2'b01, 2'b01, "ee_eq");
    run(1, 8'h48, 8'h40, 5, 0, 2'b10, 2'b01, "ee_gt5");

    // start held high: second capture only after DONE->IDLE.
    tick();
    Av[0] = 8'hFF;
    Bv[0] = 8'h00;
    st[0] = 1'b1;
    tick();
    Av[0] = 8'h00;
    Bv[0] = 8'hFF;
    chk("hold_busy", bz[0], 1);
    wait_done(0, lat, bcnt, pq1);
    chk("hold1_lat", lat, 8);
    chk("hold1_z", zo[0], 0);
    chk("hold1_pq", pqo[0], 2'b10);
    tick();
    chk("hold_idle_busy", bz[0], 0);
    chk("hold_idle_done", dn[0], 0);
    tick();
    chk("hold2_busy", bz[0], 1);
    chk("hold2_pq_reload", pqo[0], 2'b01);
    Av[0] = 8'hFF;
    Bv[0] = 8'h00;
    wait_done(0, lat, bcnt, pq1);
    chk("hold2_lat", lat, 8);
    chk("hold2_z", zo[0], 1);
    chk("hold2_pq", pqo[0], 2'b11);
    st[0] = 1'b0;
    tick();

    // Reset on the 4th RUN edge aborts silently.
    tick();
    Av[0] = 8'h01;
    Bv[0] = 8'h02;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bz[0], 0);
    chk("abort_done", dn[0], 0);
    chk("abort_z", zo[0], 0);
    chk("abort_pq", pqo[0], 2'b01);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (dn[0] || bz[0]) seen++;
      tick();
    end
    chk("abort_quiet", seen, 0);
    run(0, 8'h01, 8'h02, 8, 1, 2'b11, 2'b01, "post_abort");

    // N=1 build.
    run(2, 8'h01, 8'h00, 1, 0, 2'b10, 2'b10, "n1_gt");
    run(2, 8'h00, 8'h00, 1, 1, 2'b01, 2'b01, "n1_eq");
    run(2, 8'h00, 8'h01, 1, 1, 2'b11, 2'b11, "n1_lt");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
